// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and imem.
// One request is outstanding at most; requests use valid/ready, responses are valid-only.
interface fetch_pc_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// PC generator and IF/ID register: one imem request in flight, 2-cycle best-case fetch.
// Stall freezes PC and IF/ID (a response arriving under stall is parked); branch flushes.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  fetch_pc_unit_if.master        imem,
  output logic                   ifid_valid,
  output logic [31:0]            ifid_pc4,
  output logic [31:0]            ifid_instr,
  output logic                   misalign_err
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] hold_q, hold_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        misalign_q, misalign_d;

  logic        req_fire;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;
  assign req_fire = (state_q == S_REQ) && imem.imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      hold_q       <= 32'h00000000;
      ifid_valid_q <= 1'b0;
      ifid_pc4_q   <= 32'h00000000;
      ifid_instr_q <= 32'h00000000;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      hold_q       <= hold_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      misalign_q   <= misalign_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    hold_d       = hold_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    misalign_d   = 1'b0;

    if (branch_taken) begin
      pc_d         = {branch_target[31:2], 2'b00};
      ifid_valid_d = 1'b0;
      hold_d       = 32'h00000000;
      misalign_d   = |branch_target[1:0];
      kill_d       = 1'b0;
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          // A response landing on the branch cycle retires the stale request itself.
          if (imem.imem_rsp_valid) begin
            state_d = S_REQ;
          end else begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rsp_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else if (stall) begin
              hold_d  = imem.imem_rsp_data;
              state_d = S_HOLD;
            end else begin
              ifid_valid_d = 1'b1;
              ifid_pc4_d   = pc_plus4;
              ifid_instr_d = imem.imem_rsp_data;
              pc_d         = pc_plus4;
              state_d      = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ifid_valid_d = 1'b1;
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = hold_q;
            pc_d         = pc_plus4;
            state_d      = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  assign imem.imem_req_valid = (state_q == S_REQ);
  assign imem.imem_addr      = pc_q;
  assign ifid_valid          = ifid_valid_q;
  assign ifid_pc4            = ifid_pc4_q;
  assign ifid_instr          = ifid_instr_q;
  assign misalign_err        = misalign_q;

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock in the block.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port stall  input  1  hazard-unit stall; holds PC and IF/ID.
REQ-005 SHALL have port branch_taken  input  1  single-cycle redirect request.
REQ-006 SHALL have port branch_target  input  32  redirect address.
REQ-007 SHALL have port imem_req_valid  output  1  instruction-memory request valid.
REQ-008 SHALL have port imem_addr  output  32  request address (current PC).
REQ-009 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-010 SHALL have port imem_rsp_valid  input  1  instruction-word response valid.
REQ-011 SHALL have port imem_rsp_data  input  32  instruction word.
REQ-012 SHALL have port ifid_valid  output  1  IF/ID register holds a live instruction.
REQ-013 SHALL have port ifid_pc4  output  32  PC+4 of the IF/ID instruction.
REQ-014 SHALL have port ifid_instr  output  32  IF/ID instruction word.
REQ-015 SHALL have port misalign_err  output  1  one-cycle pulse when a redirect target has a nonzero addr[1:0].

Function
REQ-016 SHALL implement the state machine S_REQ, S_WAIT, S_HOLD.
REQ-017 SHALL drive imem_req_valid = 1 only in S_REQ, with imem_addr = pc.
REQ-018 SHALL move from S_REQ to S_WAIT on the edge where imem_req_valid && imem_req_ready, with at most one request outstanding.
REQ-019 SHALL handle imem_rsp_valid in S_WAIT without stall as follows: load ifid_instr = rsp_data, ifid_pc4 = pc+4 and ifid_valid = 1; set pc <= pc+4; go to S_REQ.
REQ-020 SHALL handle imem_rsp_valid in S_WAIT with stall as follows: capture rsp_data in a hold buffer; leave IF/ID and pc unchanged; go to S_HOLD.
REQ-021 SHALL, in S_HOLD with stall low, load IF/ID from the hold buffer, set pc <= pc+4 and go to S_REQ; with stall high it SHALL remain in S_HOLD.
REQ-022 SHALL leave ifid_valid, ifid_pc4 and ifid_instr unchanged in every cycle where stall = 1 and branch_taken = 0.
REQ-023 SHALL compute pc+4 modulo 2^32, so 32'hFFFFFFFC increments to 32'h00000000 with no error flag.
REQ-024 SHALL give branch_taken priority over stall and every state, in any cycle: pc <= {branch_target[31:2], 2'b00}; ifid_valid <= 0 (flush); hold buffer discarded.
REQ-025 SHALL, on a branch in S_WAIT, or in S_REQ on the same edge the request is accepted, set a kill flag; the next response is dropped with IF/ID untouched, and the FSM returns to S_REQ.
REQ-026 SHALL, on a branch in S_REQ without acceptance, go to or stay in S_REQ and present the new address the next cycle.
REQ-027 SHALL, on a branch in S_HOLD, go to S_REQ.
REQ-028 SHALL, when branch_taken and branch_target[1:0] != 0, pulse misalign_err for exactly one cycle, registered, on the edge after the branch.
REQ-029 SHALL ignore imem_rsp_valid in S_REQ and S_HOLD.
REQ-030 SHALL have a minimum fetch throughput of one instruction per 2 cycles: req accepted at edge N, rsp at N+1, IF/ID visible after edge N+1.

Reset
REQ-031 SHALL, while rst is high at a clock edge, set: pc = RESET_PC; state = S_REQ; ifid_valid = 0; ifid_pc4 = 0; ifid_instr = 32'h00000000 (NOP); misalign_err = 0; kill flag and hold buffer cleared.
REQ-032 SHALL drop any response arriving after a reset asserted mid-transaction; the first request after reset SHALL be to RESET_PC.
REQ-033 SHALL give rst priority over branch_taken and stall.

Verification
REQ-034 SHALL be verified for sequential fetch: reset, ready = 1, 1-cycle rsp latency -> addresses 0x0, 0x4, 0x8; ifid_pc4 = 0x4, 0x8, 0xC; one instruction per 2 cycles.
REQ-035 SHALL be verified for wrap: RESET_PC = 32'hFFFFFFFC, fetch two -> ifid_pc4 = 0x00000000, then next imem_addr = 0x00000000.
REQ-036 SHALL be verified for stall: stall high when rsp 0x8C220004 arrives -> IF/ID unchanged 3 cycles, pc held; stall low -> ifid_instr = 0x8C220004 next edge.
REQ-037 SHALL be verified for branch with an outstanding request: branch_taken, target 0x100, while in S_WAIT -> ifid_valid = 0, stale response dropped, next imem_addr = 0x100.
REQ-038 SHALL be verified for a misaligned redirect: target 0x00000206 -> misalign_err one-cycle pulse, next imem_addr = 0x00000204.
REQ-039 SHALL be verified for reset mid-wait: rst in S_WAIT, rsp arrives the next cycle -> response ignored, ifid_valid = 0, imem_addr = RESET_PC.
